// File: rtl/hazard_stall_controller_pkg.sv
// hazard_stall_controller_pkg: shared FSM encoding and width defaults for the stall controller.
//   REG_ADDR_W_DEF : default register address width
//   CNT_W_DEF      : default stall counter width
//   S_*            : debug FSM state encodings
package hazard_stall_controller_pkg;

    localparam int REG_ADDR_W_DEF = 5;
    localparam int CNT_W_DEF      = 16;

    localparam logic [1:0] S_IDLE   = 2'b00;
    localparam logic [1:0] S_RUN    = 2'b01;
    localparam logic [1:0] S_STEP   = 2'b10;
    localparam logic [1:0] S_HALTED = 2'b11;

endpackage

// File: rtl/hazard_stall_controller_hazard_detect.sv
// hazard_detect: combinational load-use / branch-operand hazard detection and control-flush request.
//   rs_d, rt_d          : source registers of the instruction in ID
//   write_reg_e         : destination register in EX
//   reg_write_e         : EX instruction writes a register
//   mem_to_reg_e        : EX instruction is a load
//   write_reg_m         : destination register in MEM
//   mem_to_reg_m        : MEM instruction is a load
//   branch_d, branch_taken_d, jump_d : control-flow info for the instruction in ID
//   stall               : hazard that forwarding cannot resolve
//   flush               : IF/ID must be cleared (taken branch or jump, no stall)
module hazard_detect
    import hazard_stall_controller_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic [REG_ADDR_W-1:0] rs_d,
    input  logic [REG_ADDR_W-1:0] rt_d,
    input  logic [REG_ADDR_W-1:0] write_reg_e,
    input  logic                  reg_write_e,
    input  logic                  mem_to_reg_e,
    input  logic [REG_ADDR_W-1:0] write_reg_m,
    input  logic                  mem_to_reg_m,
    input  logic                  branch_d,
    input  logic                  branch_taken_d,
    input  logic                  jump_d,
    output logic                  stall,
    output logic                  flush
);

    logic hit_e;
    logic hit_m;
    logic lw_stall;
    logic br_stall;

    // Register 0 is hard-wired, so a write to it never creates a dependency.
    assign hit_e = (write_reg_e != '0) & ((write_reg_e == rs_d) | (write_reg_e == rt_d));
    assign hit_m = (write_reg_m != '0) & ((write_reg_m == rs_d) | (write_reg_m == rt_d));

    assign lw_stall = mem_to_reg_e & hit_e;
    // The branch comparator sits in ID: an ALU result still in EX or load data still in MEM is too late.
    assign br_stall = branch_d & ((reg_write_e & hit_e) | (mem_to_reg_m & hit_m));

    assign stall = lw_stall | br_stall;
    // A stalled branch is re-evaluated next cycle, so it must not flush yet.
    assign flush = (jump_d | (branch_d & branch_taken_d)) & ~stall;

endmodule

// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: pipeline stall/flush sequencing with a run/step/halt debug FSM and stall counter.
//   i_clk, i_rst_n        : clock, synchronous active-low reset
//   i_instr_rs_D/rt_D     : ID source registers
//   i_write_reg_E, i_reg_write_E, i_mem_to_reg_E : EX destination info
//   i_write_reg_M, i_mem_to_reg_M                : MEM destination info
//   i_branch_D, i_branch_taken_D, i_jump_D       : ID control flow
//   i_halt_W              : halt instruction retiring in WB
//   i_run, i_step         : debug free-run level and single-step pulse
//   o_stage_en            : global enable for PC and pipeline registers
//   o_stall_F/o_stall_D   : hold PC / IF-ID
//   o_flush_D/o_flush_E   : clear IF-ID / ID-EX
//   o_halted              : FSM is in HALTED
//   o_stall_count         : saturating count of executed hazard stall cycles
module hazard_stall_controller
    import hazard_stall_controller_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [REG_ADDR_W-1:0] i_instr_rs_D,
    input  logic [REG_ADDR_W-1:0] i_instr_rt_D,
    input  logic [REG_ADDR_W-1:0] i_write_reg_E,
    input  logic                  i_reg_write_E,
    input  logic                  i_mem_to_reg_E,
    input  logic [REG_ADDR_W-1:0] i_write_reg_M,
    input  logic                  i_mem_to_reg_M,
    input  logic                  i_branch_D,
    input  logic                  i_branch_taken_D,
    input  logic                  i_jump_D,
    input  logic                  i_halt_W,
    input  logic                  i_run,
    input  logic                  i_step,
    output logic                  o_stage_en,
    output logic                  o_stall_F,
    output logic                  o_stall_D,
    output logic                  o_flush_D,
    output logic                  o_flush_E,
    output logic                  o_halted,
    output logic [CNT_W-1:0]      o_stall_count
);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             hz_stall;
    logic             hz_flush;
    logic             stall_act;
    logic [CNT_W-1:0] count;

    hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_hazard_detect (
        .rs_d           (i_instr_rs_D),
        .rt_d           (i_instr_rt_D),
        .write_reg_e    (i_write_reg_E),
        .reg_write_e    (i_reg_write_E),
        .mem_to_reg_e   (i_mem_to_reg_E),
        .write_reg_m    (i_write_reg_M),
        .mem_to_reg_m   (i_mem_to_reg_M),
        .branch_d       (i_branch_D),
        .branch_taken_d (i_branch_taken_D),
        .jump_d         (i_jump_D),
        .stall          (hz_stall),
        .flush          (hz_flush)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = i_run ? S_RUN : (i_step ? S_STEP : S_IDLE);
            S_RUN:   state_nxt = i_halt_W ? S_HALTED : (i_run ? S_RUN : S_IDLE);
            // Always drop back through IDLE so a held step gives one enabled cycle per two clocks.
            S_STEP:  state_nxt = i_halt_W ? S_HALTED : S_IDLE;
            default: state_nxt = S_HALTED;
        endcase
    end

    assign o_stage_en = (state == S_RUN) | (state == S_STEP);
    assign o_halted   = (state == S_HALTED);
    assign stall_act  = o_stage_en & hz_stall;
    assign o_stall_F  = stall_act;
    assign o_stall_D  = stall_act;
    assign o_flush_E  = stall_act;
    assign o_flush_D  = o_stage_en & hz_flush;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
            count <= '0;
        end else begin
            state <= state_nxt;
            if (stall_act && count != '1)
                count <= count + 1'b1;
        end
    end

    assign o_stall_count = count;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb_hazard_stall_controller: directed and randomized checks against a behavioural model of the controller.
module tb_hazard_stall_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs, rt, wr_e, wr_m;
    logic       rw_e, mtr_e, mtr_m, br, br_tk, jmp, halt, run, step;
    logic       stage_en, stall_f, stall_d, flush_d, flush_e, halted;
    logic [15:0] stall_count;

    int n_cmp = 0;
    int n_bad = 0;
    // Model: mode 0 = idle, 1 = free-running, 2 = single step, 3 = halted.
    int m_mode;
    int m_cnt;

    always #5 clk = ~clk;

    hazard_stall_controller dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_instr_rs_D     (rs),
        .i_instr_rt_D     (rt),
        .i_write_reg_E    (wr_e),
        .i_reg_write_E    (rw_e),
        .i_mem_to_reg_E   (mtr_e),
        .i_write_reg_M    (wr_m),
        .i_mem_to_reg_M   (mtr_m),
        .i_branch_D       (br),
        .i_branch_taken_D (br_tk),
        .i_jump_D         (jmp),
        .i_halt_W         (halt),
        .i_run            (run),
        .i_step           (step),
        .o_stage_en       (stage_en),
        .o_stall_F        (stall_f),
        .o_stall_D        (stall_d),
        .o_flush_D        (flush_d),
        .o_flush_E        (flush_e),
        .o_halted         (halted),
        .o_stall_count    (stall_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_hz();
        rs = 0; rt = 0; wr_e = 0; wr_m = 0;
        rw_e = 0; mtr_e = 0; mtr_m = 0; br = 0; br_tk = 0; jmp = 0;
    endtask

    // Called just after a negedge with inputs set: checks outputs, then advances the model across the posedge.
    task automatic tick();
        bit en, uses_e, uses_m, lw, bs, st, fl;
        #1;
        en     = (m_mode == 1) || (m_mode == 2);
        uses_e = (wr_e != 0) && (wr_e == rs || wr_e == rt);
        uses_m = (wr_m != 0) && (wr_m == rs || wr_m == rt);
        lw     = mtr_e && uses_e;
        bs     = br && ((rw_e && uses_e) || (mtr_m && uses_m));
        st     = en && (lw || bs);
        fl     = en && (jmp || (br && br_tk)) && !st;
        check("stage_en", 32'(stage_en), 32'(en));
        check("stall_F", 32'(stall_f), 32'(st));
        check("stall_D", 32'(stall_d), 32'(st));
        check("flush_E", 32'(flush_e), 32'(st));
        check("flush_D", 32'(flush_d), 32'(fl));
        check("halted", 32'(halted), 32'(m_mode == 3));
        check("stall_count", 32'(stall_count), 32'(m_cnt));
        if (!rst_n) begin
            m_mode = 0;
            m_cnt  = 0;
        end else begin
            if (st && m_cnt < 65535) m_cnt++;
            if (m_mode == 0)      m_mode = run ? 1 : (step ? 2 : 0);
            else if (m_mode == 1) m_mode = halt ? 3 : (run ? 1 : 0);
            else if (m_mode == 2) m_mode = halt ? 3 : 0;
        end
        @(negedge clk);
    endtask

    initial begin
        clear_hz();
        halt = 0; run = 0; step = 0; rst_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        m_mode = 0;
        m_cnt  = 0;
        tick();
        // Leave reset with run asserted: idle one cycle, then enabled.
        rst_n = 1; run = 1;
        tick();
        tick();
        // Load-use on rs.
        mtr_e = 1; wr_e = 5; rs = 5;
        tick();
        clear_hz();
        tick();
        // Branch on a value still in EX, then on load data in MEM; taken branch must not flush while stalled.
        br = 1; br_tk = 1; rs = 3; rw_e = 1; wr_e = 3;
        tick();
        rw_e = 0; wr_e = 0; mtr_m = 1; wr_m = 3;
        tick();
        clear_hz();
        tick();
        // Register 0 never hazards; a jump flushes IF/ID.
        mtr_e = 1; wr_e = 0; rs = 0; rt = 0;
        tick();
        clear_hz();
        jmp = 1;
        tick();
        clear_hz();
        tick();
        // Three separate step pulses from idle, with a load-use hazard present.
        run = 0;
        tick();
        mtr_e = 1; wr_e = 7; rt = 7;
        for (int i = 0; i < 3; i++) begin
            step = 1;
            tick();
            step = 0;
            tick();
            tick();
        end
        // Held step: enabled every other cycle.
        step = 1;
        repeat (4) tick();
        step = 0;
        clear_hz();
        tick();
        // Halt wins over run dropping; halted ignores run/step until reset.
        run = 1;
        tick();
        halt = 1; run = 0;
        tick();
        halt = 0; run = 1; step = 1;
        mtr_e = 1; wr_e = 4; rs = 4;
        repeat (3) tick();
        rst_n = 0;
        tick();
        rst_n = 1; run = 0; step = 0;
        clear_hz();
        tick();
        // Randomized traffic with small register numbers so dependencies are frequent.
        for (int i = 0; i < 4000; i++) begin
            rst_n = ($urandom % 300) != 0;
            run   = ($urandom % 5) != 0;
            step  = $urandom % 2;
            halt  = ($urandom % 60) == 0;
            rs    = 5'($urandom % 6);
            rt    = 5'($urandom % 6);
            wr_e  = 5'($urandom % 6);
            wr_m  = 5'($urandom % 6);
            rw_e  = $urandom % 2;
            mtr_e = $urandom % 2;
            mtr_m = $urandom % 2;
            br    = $urandom % 2;
            br_tk = $urandom % 2;
            jmp   = ($urandom % 4) == 0;
            tick();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
